// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS core: FETCH/DECODE/EXECUTE/MEM/WB sequencing with a bounded memory wait.
// Optional macro ADDI_SUPPORT_EN adds the ADDIEX/ADDIWB path for opcode 001000.
module multicycle_control #(
  parameter logic [3:0] MEM_WAIT_MAX = 4'd15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOP,
  output logic [1:0] PCSource,
  output logic       Illegal,
  output logic       MemFault,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       mem_wait;

  // Zero gates the PC enable in the datapath; this FSM only raises PCWriteCond.
  logic unused_zero;
  assign unused_zero = Zero;

  assign State = state_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOP       = 2'b00;
    PCSource    = 2'b00;
    Illegal     = 1'b0;
    MemFault    = 1'b0;
    mem_wait    = 1'b0;
    cnt_next    = 4'd0;
    state_next  = S_FETCH;

    case (state_reg)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (MemReady) state_next = S_DECODE;
        else begin
          mem_wait   = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYP:      state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
`ifdef ADDI_SUPPORT_EN
          OP_ADDI:      state_next = S_ADDIEX;
`endif
          default:      Illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) state_next = S_MEMWB;
        else begin
          mem_wait   = 1'b1;
          state_next = S_MEMRD;
        end
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (!MemReady) begin
          mem_wait   = 1'b1;
          state_next = S_MEMWR;
        end
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUOP      = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOP       = 2'b01;
        PCSource    = 2'b01;
        PCWriteCond = 1'b1;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`ifdef ADDI_SUPPORT_EN
      S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
`endif
      default: state_next = S_FETCH;
    endcase

    // A stalled access that hits the bound is abandoned; MemReady in the same cycle means no stall.
    if (mem_wait) begin
      if (cnt_reg == MEM_WAIT_MAX) begin
        MemFault   = 1'b1;
        state_next = S_FETCH;
        cnt_next   = 4'd0;
      end else begin
        cnt_next = cnt_reg + 4'd1;
      end
    end

    if (reset) begin
      PCWrite     = 1'b0;
      IRWrite     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
      MemRead     = 1'b0;
      PCWriteCond = 1'b0;
      Illegal     = 1'b0;
      MemFault    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction-level bench for multicycle_control; expected per-cycle behaviour is built from
// each instruction's step list and memory wait counts.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOP, PCSource;
  logic       Illegal, MemFault;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;
  int cycles = 0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_WAIT_MAX(4'd15)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOP(ALUOP),
    .PCSource(PCSource), .Illegal(Illegal), .MemFault(MemFault), .State(State)
  );

  // Expected control word per step, straight from the control table:
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOP,PCSource}
  function automatic logic [15:0] exp_ctl(input int st, input logic rdy);
    logic [15:0] v;
    v = 16'h0;
    case (st)
      0:  begin v[12] = 1'b1; v[5:4] = 2'b01; v[15] = rdy; v[10] = rdy; end
      1:  v[5:4] = 2'b11;
      2:  begin v[6] = 1'b1; v[5:4] = 2'b10; end
      3:  begin v[12] = 1'b1; v[13] = 1'b1; end
      4:  begin v[7] = 1'b1; v[9] = 1'b1; end
      5:  begin v[11] = 1'b1; v[13] = 1'b1; end
      6:  begin v[6] = 1'b1; v[3:2] = 2'b10; end
      7:  begin v[7] = 1'b1; v[8] = 1'b1; end
      8:  begin v[6] = 1'b1; v[3:2] = 2'b01; v[1:0] = 2'b01; v[14] = 1'b1; end
      9:  begin v[15] = 1'b1; v[1:0] = 2'b10; end
      10: begin v[6] = 1'b1; v[5:4] = 2'b10; end
      11: v[7] = 1'b1;
      default: v = 16'h0;
    endcase
    return v;
  endfunction

  function automatic logic [15:0] dut_ctl();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
            RegWrite, ALUSrcA, ALUSrcB, ALUOP, PCSource};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of a step: apply MemReady, check at the falling edge, leave 1 time unit after the rise.
  task automatic cyc(input int st, input logic rdy, input logic ill, input logic flt);
    MemReady = rdy;
    @(negedge clk);
    chk("state", 16'(State), 16'(st));
    chk("ctl", dut_ctl(), exp_ctl(st, rdy));
    chk("illegal", 16'(Illegal), 16'(ill));
    chk("memfault", 16'(MemFault), 16'(flt));
    cycles++;
    @(posedge clk); #1;
  endtask

  task automatic rst_cyc(input int st);
    @(negedge clk);
    chk("rst_state", 16'(State), 16'(st));
    chk("rst_forced", 16'({PCWrite, IRWrite, MemWrite, RegWrite, MemRead, PCWriteCond, Illegal, MemFault}), 16'h0);
    @(posedge clk); #1;
  endtask

  // w stalled cycles in a memory step; every 16th consecutive stall is a fault.
  task automatic mem_wait(input int st, input int w);
    for (int i = 0; i < w; i++) cyc(st, 1'b0, 1'b0, (i % 16) == 15);
  endtask

  task automatic run(input logic [5:0] op, input int fw, input int mw);
    int start;
    start = cycles;
    Opcode = op;
    Zero = 1'($urandom);
    mem_wait(0, fw);
    cyc(0, 1'b1, 1'b0, 1'b0);
    case (op)
      LW: begin
        cyc(1, 1'($urandom), 1'b0, 1'b0);
        cyc(2, 1'($urandom), 1'b0, 1'b0);
        mem_wait(3, mw);
        if (mw < 16) begin
          cyc(3, 1'b1, 1'b0, 1'b0);
          cyc(4, 1'($urandom), 1'b0, 1'b0);
        end
      end
      SW: begin
        cyc(1, 1'($urandom), 1'b0, 1'b0);
        cyc(2, 1'($urandom), 1'b0, 1'b0);
        mem_wait(5, mw);
        if (mw < 16) cyc(5, 1'b1, 1'b0, 1'b0);
      end
      RT: begin
        cyc(1, 1'($urandom), 1'b0, 1'b0);
        cyc(6, 1'($urandom), 1'b0, 1'b0);
        cyc(7, 1'($urandom), 1'b0, 1'b0);
      end
      BEQ: begin
        cyc(1, 1'($urandom), 1'b0, 1'b0);
        cyc(8, 1'($urandom), 1'b0, 1'b0);
      end
      JMP: begin
        cyc(1, 1'($urandom), 1'b0, 1'b0);
        cyc(9, 1'($urandom), 1'b0, 1'b0);
      end
`ifdef ADDI_SUPPORT_EN
      ADDI: begin
        cyc(1, 1'($urandom), 1'b0, 1'b0);
        cyc(10, 1'($urandom), 1'b0, 1'b0);
        cyc(11, 1'($urandom), 1'b0, 1'b0);
      end
`endif
      default: cyc(1, 1'($urandom), 1'b1, 1'b0);
    endcase
    $display("instr op=%b zero=%0d fetch_wait=%0d mem_wait=%0d cycles=%0d", op, Zero, fw, mw, cycles - start);
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] op;
    case ($urandom_range(0, 6))
      0: op = LW;
      1: op = SW;
      2: op = RT;
      3: op = BEQ;
      4: op = JMP;
      5: op = ADDI;
      default: begin
        op = 6'($urandom);
        while (op == LW || op == SW || op == RT || op == BEQ || op == JMP || op == ADDI)
          op = 6'($urandom);
      end
    endcase
    return op;
  endfunction

  initial begin
    reset = 1'b1;
    MemReady = 1'b0;
    Opcode = 6'd0;
    Zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_cyc(0);
    reset = 1'b0;

    // Directed: each instruction class with single-cycle memory
    run(LW, 0, 0);
    run(RT, 0, 0);
    Zero = 1'b1;
    run(BEQ, 0, 0);
    run(BEQ, 0, 0);
    run(JMP, 0, 0);
    run(SW, 0, 0);
    run(ADDI, 0, 0);

    // Reset held three cycles while a store is waiting in MEMWR
    Opcode = SW;
    cyc(0, 1'b1, 1'b0, 1'b0);
    cyc(1, 1'b1, 1'b0, 1'b0);
    cyc(2, 1'b1, 1'b0, 1'b0);
    MemReady = 1'b0;
    reset = 1'b1;
    rst_cyc(5);
    rst_cyc(0);
    rst_cyc(0);
    reset = 1'b0;
    run(RT, 0, 0);

    // Wait bound: 20 stalled fetch cycles fault once; 15 stalls then ready is a clean completion
    run(JMP, 20, 0);
    run(RT, 15, 0);
    run(LW, 0, 15);
    run(LW, 0, 16);
    run(SW, 0, 15);
    run(SW, 0, 16);

    for (int n = 0; n < 60; n++)
      run(pick_op(), $urandom_range(0, 4), $urandom_range(0, 4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit exceeded");
  end

endmodule
